// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect. A taken control transfer that
// arrives while the pipeline is stalled is parked until the stall clears.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_branch_valid,
  input  logic [3:0]       i_branch_type,
  input  logic [1:0]       i_zero,
  input  logic [31:0]      i_branch_target,
  input  logic [31:0]      i_jr_target,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_plus4,
  output logic             o_flush,
  output logic             o_redirect_pending,
  output logic [CNT_W-1:0] o_taken_cnt
);

  localparam logic [3:0] BT_BEQ  = 4'd1;
  localparam logic [3:0] BT_BNE  = 4'd2;
  localparam logic [3:0] BT_BLEZ = 4'd3;
  localparam logic [3:0] BT_BGTZ = 4'd4;
  localparam logic [3:0] BT_BLTZ = 4'd5;
  localparam logic [3:0] BT_BGEZ = 4'd6;
  localparam logic [3:0] BT_J    = 4'd7;
  localparam logic [3:0] BT_JAL  = 4'd8;
  localparam logic [3:0] BT_JR   = 4'd9;

  localparam logic [1:0] CMP_EQUAL = 2'b01;
  localparam logic [1:0] CMP_LT    = 2'b10;
  localparam logic [1:0] CMP_GT    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_latchedTarget;
  logic               r_flush;
  logic [CNT_W-1:0]   r_takenCnt;

  state_t             w_nextState;
  logic [31:0]        w_nextPc;
  logic [31:0]        w_nextLatched;
  logic               w_applyRedirect;
  logic               w_condTaken;
  logic               w_taken;
  logic [31:0]        w_target;
  logic [31:0]        w_targetAligned;
  logic [31:0]        w_pcPlus4;
  logic               w_cntSaturated;

  // Condition decode; a DEFAULT compare code never matches any condition.
  always_comb begin
    w_condTaken = 1'b0;
    case (i_branch_type)
      BT_BEQ:  w_condTaken = (i_zero == CMP_EQUAL);
      BT_BNE:  w_condTaken = (i_zero == CMP_LT) || (i_zero == CMP_GT);
      BT_BLEZ: w_condTaken = (i_zero == CMP_EQUAL) || (i_zero == CMP_LT);
      BT_BGTZ: w_condTaken = (i_zero == CMP_GT);
      BT_BLTZ: w_condTaken = (i_zero == CMP_LT);
      BT_BGEZ: w_condTaken = (i_zero == CMP_EQUAL) || (i_zero == CMP_GT);
      BT_J:    w_condTaken = 1'b1;
      BT_JAL:  w_condTaken = 1'b1;
      BT_JR:   w_condTaken = 1'b1;
      default: w_condTaken = 1'b0;
    endcase
  end

  assign w_taken         = i_branch_valid & w_condTaken;
  assign w_target        = (i_branch_type == BT_JR) ? i_jr_target : i_branch_target;
  assign w_targetAligned = w_target & ~32'h0000_0003;
  assign w_pcPlus4       = r_pc + 32'd4;
  assign w_cntSaturated  = &r_takenCnt;

  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pc;
    w_nextLatched   = r_latchedTarget;
    w_applyRedirect = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_stall) begin
          if (w_taken) begin
            w_nextPc        = w_targetAligned;
            w_applyRedirect = 1'b1;
          end else begin
            w_nextPc = w_pcPlus4;
          end
        end else if (w_taken) begin
          w_nextLatched = w_targetAligned;
          w_nextState   = PENDING;
        end
      end
      // Parked redirect: new ID-stage inputs are ignored until it is applied.
      PENDING: begin
        if (!i_stall) begin
          w_nextPc        = r_latchedTarget;
          w_applyRedirect = 1'b1;
          w_nextState     = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_pc            <= RESET_PC;
      r_latchedTarget <= 32'h0000_0000;
      r_flush         <= 1'b0;
      r_takenCnt      <= '0;
    end else begin
      r_state         <= w_nextState;
      r_pc            <= w_nextPc;
      r_latchedTarget <= w_nextLatched;
      r_flush         <= w_applyRedirect;
      if (w_applyRedirect && !w_cntSaturated) begin
        r_takenCnt <= r_takenCnt + CNT_ONE;
      end
    end
  end

  assign o_pc               = r_pc;
  assign o_pc_plus4         = w_pcPlus4;
  assign o_flush            = r_flush;
  assign o_redirect_pending = (r_state == PENDING);
  assign o_taken_cnt        = r_takenCnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: default instance plus a wrap/saturation
// instance (RESET_PC = 0xFFFF_FFFC, CNT_W = 2).
module tb_pc_redirect_unit;

  logic clk;

  logic        aRst = 1'b1, aStall = 1'b0, aValid = 1'b0;
  logic [3:0]  aType = 4'd0;
  logic [1:0]  aZero = 2'd0;
  logic [31:0] aTgt = 32'd0, aJr = 32'd0;
  logic [31:0] aPc, aPcPlus4;
  logic        aFlush, aPend;
  logic [15:0] aCnt;

  logic        bRst = 1'b1, bStall = 1'b0, bValid = 1'b0;
  logic [3:0]  bType = 4'd0;
  logic [1:0]  bZero = 2'd0;
  logic [31:0] bTgt = 32'd0, bJr = 32'd0;
  logic [31:0] bPc, bPcPlus4;
  logic        bFlush, bPend;
  logic [1:0]  bCnt;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];

  pc_redirect_unit dutA (
    .i_clk(clk), .i_rst(aRst), .i_stall(aStall), .i_branch_valid(aValid),
    .i_branch_type(aType), .i_zero(aZero), .i_branch_target(aTgt),
    .i_jr_target(aJr), .o_pc(aPc), .o_pc_plus4(aPcPlus4), .o_flush(aFlush),
    .o_redirect_pending(aPend), .o_taken_cnt(aCnt)
  );

  pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dutB (
    .i_clk(clk), .i_rst(bRst), .i_stall(bStall), .i_branch_valid(bValid),
    .i_branch_type(bType), .i_zero(bZero), .i_branch_target(bTgt),
    .i_jr_target(bJr), .o_pc(bPc), .o_pc_plus4(bPcPlus4), .o_flush(bFlush),
    .o_redirect_pending(bPend), .o_taken_cnt(bCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] expP4;
    expP4 = e.pc + 32'd4;
    if (!e.sel) begin
      checkField({e.name, ".pc"}, aPc, e.pc);
      checkField({e.name, ".pc_plus4"}, aPcPlus4, expP4);
      checkField({e.name, ".flush"}, {31'd0, aFlush}, {31'd0, e.flush});
      checkField({e.name, ".pending"}, {31'd0, aPend}, {31'd0, e.pend});
      checkField({e.name, ".taken_cnt"}, {16'd0, aCnt}, {16'd0, e.cnt});
    end else begin
      checkField({e.name, ".pc"}, bPc, e.pc);
      checkField({e.name, ".pc_plus4"}, bPcPlus4, expP4);
      checkField({e.name, ".flush"}, {31'd0, bFlush}, {31'd0, e.flush});
      checkField({e.name, ".pending"}, {31'd0, bPend}, {31'd0, e.pend});
      checkField({e.name, ".taken_cnt"}, {30'd0, bCnt}, {16'd0, e.cnt});
    end
  endtask

  // Monitor: outputs settle after each rising edge; one expectation per edge.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) checkOutput(q.pop_front());
  end

  task automatic applyStimulus(input bit sel, input logic rst, input logic stall,
                               input logic valid, input logic [3:0] btype,
                               input logic [1:0] zero, input logic [31:0] tgt,
                               input logic [31:0] jr, input logic [31:0] ePc,
                               input logic eFlush, input logic ePend,
                               input logic [15:0] eCnt, input string name);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      aRst = rst; aStall = stall; aValid = valid; aType = btype;
      aZero = zero; aTgt = tgt; aJr = jr;
    end else begin
      bRst = rst; bStall = stall; bValid = valid; bType = btype;
      bZero = zero; bTgt = tgt; bJr = jr;
    end
    e.sel = sel; e.pc = ePc; e.flush = eFlush; e.pend = ePend;
    e.cnt = eCnt; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    // Default instance: reset, sequential fetch, branch decode, stall/pending.
    applyStimulus(0, 1, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3000, 0, 0, 16'd0, "rst");
    applyStimulus(0, 1, 1, 1, 4'd7, 2'd0, 32'h9000,      32'h0,    32'h0000_3000, 0, 0, 16'd0, "rstPrio");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3004, 0, 0, 16'd0, "seq1");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3008, 0, 0, 16'd0, "seq2");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_300C, 0, 0, 16'd0, "seq3");
    applyStimulus(0, 0, 0, 1, 4'd1, 2'd1, 32'h3100,      32'h0,    32'h0000_3100, 1, 0, 16'd1, "beqEq");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3104, 0, 0, 16'd1, "afterBeq");
    applyStimulus(0, 0, 0, 1, 4'd2, 2'd0, 32'h3200,      32'h0,    32'h0000_3108, 0, 0, 16'd1, "bneDef");
    applyStimulus(0, 0, 0, 1, 4'd6, 2'd2, 32'h3300,      32'h0,    32'h0000_310C, 0, 0, 16'd1, "bgezLt");
    applyStimulus(0, 0, 0, 1, 4'd3, 2'd2, 32'h5000,      32'h0,    32'h0000_5000, 1, 0, 16'd2, "blezLt");
    applyStimulus(0, 0, 0, 1, 4'd4, 2'd1, 32'h5800,      32'h0,    32'h0000_5004, 0, 0, 16'd2, "bgtzEq");
    applyStimulus(0, 0, 0, 1, 4'd7, 2'd0, 32'h6000,      32'h0,    32'h0000_6000, 1, 0, 16'd3, "j");
    applyStimulus(0, 0, 0, 1, 4'd8, 2'd0, 32'h7006,      32'h0,    32'h0000_7004, 1, 0, 16'd4, "jalAlign");
    applyStimulus(0, 0, 0, 1, 4'd12, 2'd1, 32'h7100,     32'h0,    32'h0000_7008, 0, 0, 16'd4, "type12");
    applyStimulus(0, 0, 0, 1, 4'd5, 2'd3, 32'h7200,      32'h0,    32'h0000_700C, 0, 0, 16'd4, "bltzGt");
    applyStimulus(0, 0, 0, 1, 4'd2, 2'd3, 32'h8000,      32'h0,    32'h0000_8000, 1, 0, 16'd5, "bneGt");
    applyStimulus(0, 0, 0, 1, 4'd0, 2'd1, 32'h8100,      32'h0,    32'h0000_8004, 0, 0, 16'd5, "noneValid");
    applyStimulus(0, 0, 0, 0, 4'd1, 2'd1, 32'h8200,      32'h0,    32'h0000_8008, 0, 0, 16'd5, "beqNotValid");
    applyStimulus(0, 0, 1, 1, 4'd9, 2'd0, 32'h9990_0000, 32'h4003, 32'h0000_8008, 0, 1, 16'd5, "jrStall");
    applyStimulus(0, 0, 1, 1, 4'd1, 2'd1, 32'hA000,      32'h0,    32'h0000_8008, 0, 1, 16'd5, "pendHold1");
    applyStimulus(0, 0, 1, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_8008, 0, 1, 16'd5, "pendHold2");
    applyStimulus(0, 0, 0, 1, 4'd7, 2'd0, 32'hB000,      32'h0,    32'h0000_4000, 1, 0, 16'd6, "pendApply");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_4004, 0, 0, 16'd6, "afterApply");
    applyStimulus(0, 0, 1, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_4004, 0, 0, 16'd6, "idleStall");
    applyStimulus(0, 0, 1, 1, 4'd1, 2'd2, 32'hC000,      32'h0,    32'h0000_4004, 0, 0, 16'd6, "idleStallNt");
    applyStimulus(0, 0, 1, 1, 4'd9, 2'd0, 32'h0,         32'h4400, 32'h0000_4004, 0, 1, 16'd6, "jrStall2");
    applyStimulus(0, 1, 1, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3000, 0, 0, 16'd0, "rstPending");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3004, 0, 0, 16'd0, "rstRelease1");
    applyStimulus(0, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_3008, 0, 0, 16'd0, "rstRelease2");

    // Wrap/saturation instance.
    applyStimulus(1, 1, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'hFFFF_FFFC, 0, 0, 16'd0, "bRst");
    applyStimulus(1, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_0000, 0, 0, 16'd0, "bWrap");
    applyStimulus(1, 0, 0, 1, 4'd7, 2'd0, 32'h100,       32'h0,    32'h0000_0100, 1, 0, 16'd1, "bJ1");
    applyStimulus(1, 0, 0, 1, 4'd7, 2'd0, 32'h200,       32'h0,    32'h0000_0200, 1, 0, 16'd2, "bJ2");
    applyStimulus(1, 0, 0, 1, 4'd7, 2'd0, 32'h300,       32'h0,    32'h0000_0300, 1, 0, 16'd3, "bJ3");
    applyStimulus(1, 0, 0, 1, 4'd7, 2'd0, 32'h400,       32'h0,    32'h0000_0400, 1, 0, 16'd3, "bJ4Sat");
    applyStimulus(1, 0, 0, 0, 4'd0, 2'd0, 32'h0,         32'h0,    32'h0000_0404, 0, 0, 16'd3, "bAfter");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_3000, PC value after reset; CNT_W, 16, width of taken-redirect counter.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall  in  1  pipeline hold request from the hazard unit; PC and state SHALL hold while high.
REQ-006 branch_valid  in  1  ID-stage instruction is a control-transfer instruction this cycle.
REQ-007 branch_type  in  4  0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J, 8 JAL, 9 JR; 10-15 are treated as NONE.
REQ-008 zero  in  2  compare code from branch_judge: 00 DEFAULT, 01 EQUAL, 10 LT, 11 GT (rs vs rt; rt forced to 0 upstream for zero-compare branches).
REQ-009 branch_target  in  32  PC-relative or jump target computed in ID.
REQ-010 jr_target  in  32  forwarded rs value for JR.
REQ-011 pc  out  32  current fetch address (registered).
REQ-012 pc_plus4  out  32  pc + 4, combinational, modulo 2^32.
REQ-013 flush  out  1  registered one-cycle pulse that clears IF/ID after a redirect.
REQ-014 redirect_pending  out  1  high while state is PENDING.
REQ-015 taken_cnt  out  CNT_W  count of applied redirects, saturating.

Function
REQ-016 Taken decode SHALL be: BEQ on EQUAL; BNE on LT or GT; BLEZ on EQUAL or LT; BGTZ on GT; BLTZ on LT; BGEZ on EQUAL or GT; J, JAL, JR unconditional; NONE never. zero = DEFAULT SHALL give not-taken for every conditional type.
REQ-017 Target SHALL be jr_target for JR and branch_target for all other types; bits [1:0] SHALL be forced to 00 when loaded into pc.
REQ-018 States SHALL be IDLE and PENDING; reset state IDLE.
REQ-019 IDLE, stall low, branch_valid high, taken: next pc = target, flush = 1 next cycle, taken_cnt increments, state stays IDLE.
REQ-020 IDLE, stall low, no taken branch: next pc = pc_plus4, flush = 0 next cycle.
REQ-021 IDLE, stall high, branch_valid high, taken: pc holds, target latched, state -> PENDING; flush stays 0.
REQ-022 IDLE, stall high, no taken branch: pc holds, flush = 0.
REQ-023 PENDING, stall high: pc, latched target and state hold; branch_valid, branch_type and zero are ignored.
REQ-024 PENDING, stall low: next pc = latched target, flush = 1 next cycle, taken_cnt increments, state -> IDLE; inputs this cycle are ignored.
REQ-025 Redirect latency SHALL be one cycle from the accepting edge: pc shows the target and flush is high in the same cycle.
REQ-026 flush SHALL never be high for two consecutive cycles unless two redirects are applied on consecutive edges.
REQ-027 pc + 4 SHALL wrap: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-028 taken_cnt SHALL saturate at all-ones and not wrap.
REQ-029 redirect_pending SHALL equal (state == PENDING) and be registered.

Reset
REQ-030 On rst high at a rising edge: pc = RESET_PC, flush = 0, state = IDLE, redirect_pending = 0, taken_cnt = 0, latched target = 0.
REQ-031 rst SHALL have priority over stall and branch inputs, including in PENDING; a pending redirect is discarded.
REQ-032 Outputs SHALL take their reset values from the first edge with rst high and keep them while rst stays high.

Verification
REQ-033 Release reset, no branches, 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; flush always 0.
REQ-034 pc=0x3008, BEQ with zero=01, target 0x3100, stall 0 -> next cycle pc=0x3100, flush=1, taken_cnt=1; following cycle pc=0x3104, flush=0.
REQ-035 BNE with zero=00, then BGEZ with zero=10 -> both not taken, pc advances by 4, taken_cnt unchanged.
REQ-036 JR jr_target=0x0000_4003 with stall=1 for 3 cycles -> redirect_pending=1, pc held; first cycle with stall=0 -> next pc=0x4000, flush=1, redirect_pending=0.
REQ-037 In PENDING, assert rst -> pc=0x3000, redirect_pending=0, flush=0, no redirect after rst is released.
REQ-038 Force pc to 0xFFFF_FFFC (reset with RESET_PC=0xFFFF_FFFC) -> next pc=0x0000_0000; taken_cnt with CNT_W=2 holds at 3 after a 4th redirect.
